dmem_arbiter: RTL and testbench

Arbitrates the single-ported data memory between two requesters: port 0 (core load/store path) and port 1 (loader/debug DMA). Each request is a single-word read or write carried by a req/ack handshake. The arbiter registers the winning transaction onto the data memory interface, returns the read data, and raises a stall to the core while its access is pending. It sits between the core's ALU-address/store-data path and the data memory instance.

---
 rtl/dmem_arbiter_if.sv | 52 +++++
 rtl/dmem_arbiter.sv | 161 ++++++++++++++++
 tb/tb_dmem_arbiter.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// Requester and data-memory signal bundle for dmem_arbiter.
// The arbiter takes the slave view; the requesters and memory model take the master view.
interface dmem_arbiter_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
);
   logic              req0;
   logic              we0;
   logic [ADDR_W-1:0] addr0;
   logic [DATA_W-1:0] wdata0;
   logic              ack0;
   logic              err0;
   logic [DATA_W-1:0] rdata0;
   logic              stall0;

   logic              req1;
   logic              we1;
   logic [ADDR_W-1:0] addr1;
   logic [DATA_W-1:0] wdata1;
   logic              ack1;
   logic              err1;
   logic [DATA_W-1:0] rdata1;

   logic              mem_read;
   logic              mem_write;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   logic              busy;
   logic              gnt_id;

   modport slave (
      input  req0, we0, addr0, wdata0,
      input  req1, we1, addr1, wdata1,
      input  mem_rdata,
      output ack0, err0, rdata0, stall0,
      output ack1, err1, rdata1,
      output mem_read, mem_write, mem_addr, mem_wdata,
      output busy, gnt_id
   );

   modport master (
      output req0, we0, addr0, wdata0,
      output req1, we1, addr1, wdata1,
      output mem_rdata,
      input  ack0, err0, rdata0, stall0,
      input  ack1, err1, rdata1,
      input  mem_read, mem_write, mem_addr, mem_wdata,
      input  busy, gnt_id
   );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter for a single-ported data memory.
// Each transaction runs IDLE -> ISSUE -> DONE; ack pulses in DONE.
module dmem_arbiter #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
) (
   input  logic           clk,
   input  logic           reset,
   dmem_arbiter_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t            state_q,     state_d;
   logic              last_gnt_q,  last_gnt_d;
   logic              gnt_id_q,    gnt_id_d;
   logic              mis_q,       mis_d;
   logic              busy_q,      busy_d;
   logic              mem_read_q,  mem_read_d;
   logic              mem_write_q, mem_write_d;
   logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic [1:0]        ack_q,       ack_d;
   logic [1:0]        err_q,       err_d;
   logic [DATA_W-1:0] rdata0_q,    rdata0_d;
   logic [DATA_W-1:0] rdata1_q,    rdata1_d;

   logic              win;
   logic              win_we;
   logic [ADDR_W-1:0] win_addr;
   logic [DATA_W-1:0] win_wdata;
   logic              win_mis;

   // Winner selection: a lone request wins; a tie goes to the port not served last.
   always_comb begin
      win       = 1'b0;
      win_we    = 1'b0;
      win_addr  = '0;
      win_wdata = '0;
      if (bus.req0 && bus.req1) begin
         win = ~last_gnt_q;
      end else begin
         win = bus.req1;
      end
      if (win) begin
         win_we    = bus.we1;
         win_addr  = bus.addr1;
         win_wdata = bus.wdata1;
      end else begin
         win_we    = bus.we0;
         win_addr  = bus.addr0;
         win_wdata = bus.wdata0;
      end
      win_mis = |win_addr[1:0];
   end

   // Next-state and next-output logic; memory strobes are pre-computed so they are flops in ISSUE.
   always_comb begin
      state_d     = state_q;
      last_gnt_d  = last_gnt_q;
      gnt_id_d    = gnt_id_q;
      mis_d       = mis_q;
      mem_read_d  = 1'b0;
      mem_write_d = 1'b0;
      mem_addr_d  = '0;
      mem_wdata_d = '0;
      ack_d       = 2'b00;
      err_d       = 2'b00;
      rdata0_d    = rdata0_q;
      rdata1_d    = rdata1_q;

      case (state_q)
         IDLE: begin
            if (bus.req0 || bus.req1) begin
               state_d     = ISSUE;
               gnt_id_d    = win;
               last_gnt_d  = win;
               mis_d       = win_mis;
               mem_read_d  = ~win_we & ~win_mis;
               mem_write_d = win_we & ~win_mis;
               mem_addr_d  = win_addr;
               mem_wdata_d = win_wdata;
            end
         end
         ISSUE: begin
            state_d           = DONE;
            ack_d[gnt_id_q]   = 1'b1;
            err_d[gnt_id_q]   = mis_q;
            if (mem_read_q) begin
               if (gnt_id_q) begin
                  rdata1_d = bus.mem_rdata;
               end else begin
                  rdata0_d = bus.mem_rdata;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d != IDLE);
   end

   // Reset clears every output flop at once so a pending write strobe never reaches an edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         last_gnt_q  <= 1'b1;
         gnt_id_q    <= 1'b0;
         mis_q       <= 1'b0;
         busy_q      <= 1'b0;
         mem_read_q  <= 1'b0;
         mem_write_q <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         ack_q       <= 2'b00;
         err_q       <= 2'b00;
         rdata0_q    <= '0;
         rdata1_q    <= '0;
      end else begin
         state_q     <= state_d;
         last_gnt_q  <= last_gnt_d;
         gnt_id_q    <= gnt_id_d;
         mis_q       <= mis_d;
         busy_q      <= busy_d;
         mem_read_q  <= mem_read_d;
         mem_write_q <= mem_write_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         ack_q       <= ack_d;
         err_q       <= err_d;
         rdata0_q    <= rdata0_d;
         rdata1_q    <= rdata1_d;
      end
   end

   assign bus.ack0      = ack_q[0];
   assign bus.ack1      = ack_q[1];
   assign bus.err0      = err_q[0];
   assign bus.err1      = err_q[1];
   assign bus.rdata0    = rdata0_q;
   assign bus.rdata1    = rdata1_q;
   assign bus.mem_read  = mem_read_q;
   assign bus.mem_write = mem_write_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign bus.busy      = busy_q;
   assign bus.gnt_id    = gnt_id_q;

   // Core stall follows the live request; forced low while reset is asserted.
   assign bus.stall0    = reset & bus.req0 & ~ack_q[0];

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: stimulus queues expected acks, a monitor checks them.
module tb_dmem_arbiter;

   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      int          port;
      logic        err;
      logic [31:0] rdata;
   } exp_t;

   exp_t        sb[$];
   int          n_checks = 0;
   int          n_fail   = 0;
   int          cyc      = 0;
   int          wr_cnt   = 0;
   int          rd_cnt   = 0;
   logic [31:0] mem [0:63];
   logic        mem_init = 1'b0;

   // Memory model: word i starts as 0x1000_0000 + i; read data is combinational.
   assign bus.mem_rdata = mem[bus.mem_addr[7:2]];

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (!mem_init) begin
         for (int i = 0; i < 64; i++) mem[i] <= 32'h1000_0000 + 32'(i);
         mem_init <= 1'b1;
      end else if (reset && bus.mem_write) begin
         mem[bus.mem_addr[7:2]] <= bus.mem_wdata;
      end
      if (reset && bus.mem_write) wr_cnt <= wr_cnt + 1;
      if (reset && bus.mem_read)  rd_cnt <= rd_cnt + 1;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every ack pops one expectation.
   always @(negedge clk) begin
      exp_t e;
      int   p;
      if (reset) begin
         if (bus.mem_read || bus.mem_write)
            chk("mem_strobe_excl", 32'(bus.mem_read & bus.mem_write), 32'd0);
         if (bus.ack0 || bus.ack1) begin
            if (sb.size() == 0) begin
               chk("unexpected_ack", 32'({bus.ack1, bus.ack0}), 32'd0);
            end else begin
               e = sb.pop_front();
               p = bus.ack1 ? 1 : 0;
               chk("ack_port", 32'({bus.ack1, bus.ack0}), (e.port == 1) ? 32'd2 : 32'd1);
               chk("gnt_id", 32'(bus.gnt_id), 32'(e.port));
               chk("err", 32'(p == 1 ? bus.err1 : bus.err0), 32'(e.err));
               chk("rdata", p == 1 ? bus.rdata1 : bus.rdata0, e.rdata);
            end
         end
      end
   end

   task automatic push_exp(input int port, input logic err, input logic [31:0] rd);
      exp_t e;
      e.port  = port;
      e.err   = err;
      e.rdata = rd;
      sb.push_back(e);
   endtask

   task automatic drive(input int port, input logic rq, input logic we,
                        input logic [31:0] addr, input logic [31:0] wdata);
      if (port == 0) begin
         bus.req0 = rq; bus.we0 = we; bus.addr0 = addr; bus.wdata0 = wdata;
      end else begin
         bus.req1 = rq; bus.we1 = we; bus.addr1 = addr; bus.wdata1 = wdata;
      end
   endtask

   // Port -1 waits for either ack.
   task automatic wait_ack(input int port, output int at);
      at = -1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if ((port == 0 && bus.ack0) || (port == 1 && bus.ack1) ||
             (port < 0 && (bus.ack0 || bus.ack1))) begin
            at = cyc;
            break;
         end
      end
      if (at < 0) chk("ack_timeout", 32'd0, 32'd1);
   endtask

   // One transaction; entered and left just after a rising edge.
   task automatic txn(input int port, input logic we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic err, input logic [31:0] rd);
      int c0, at;
      push_exp(port, err, rd);
      c0 = cyc;
      drive(port, 1'b1, we, addr, wdata);
      wait_ack(port, at);
      chk("latency", 32'(at - c0), 32'd2);
      @(posedge clk); #1;
      drive(port, 1'b0, 1'b0, 32'd0, 32'd0);
   endtask

   // Both ports read (0x0 / 0x4) held high for n acks.
   task automatic sim_both(input int n);
      int c0, at, prev;
      c0   = cyc;
      prev = c0 - 1;
      drive(0, 1'b1, 1'b0, 32'h0, 32'd0);
      drive(1, 1'b1, 1'b0, 32'h4, 32'd0);
      for (int k = 0; k < n; k++) begin
         wait_ack(-1, at);
         chk("both_gap", 32'(at - prev), (k == 0) ? 32'd3 : 32'd3);
         prev = at;
      end
      @(posedge clk); #1;
      drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
      drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
   endtask

   task automatic reset_checks();
      chk("rst_ack0",      32'(bus.ack0),      32'd0);
      chk("rst_ack1",      32'(bus.ack1),      32'd0);
      chk("rst_err0",      32'(bus.err0),      32'd0);
      chk("rst_err1",      32'(bus.err1),      32'd0);
      chk("rst_rdata0",    bus.rdata0,         32'd0);
      chk("rst_rdata1",    bus.rdata1,         32'd0);
      chk("rst_mem_read",  32'(bus.mem_read),  32'd0);
      chk("rst_mem_write", 32'(bus.mem_write), 32'd0);
      chk("rst_mem_addr",  bus.mem_addr,       32'd0);
      chk("rst_mem_wdata", bus.mem_wdata,      32'd0);
      chk("rst_busy",      32'(bus.busy),      32'd0);
      chk("rst_gnt_id",    32'(bus.gnt_id),    32'd0);
      chk("rst_stall0",    32'(bus.stall0),    32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int c0, at, w0, r0;
      drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
      drive(1, 1'b0, 1'b0, 32'd0, 32'd0);

      // Reset state, with req0 high to confirm stall0 is held low.
      repeat (2) @(posedge clk);
      #1 drive(0, 1'b1, 1'b0, 32'd0, 32'd0);
      @(negedge clk);
      reset_checks();
      @(posedge clk); #1;
      drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
      reset = 1'b1;
      @(posedge clk); #1;

      // Simultaneous reads after reset: grants 0,1,0,1 three cycles apart.
      push_exp(0, 1'b0, 32'h1000_0000);
      push_exp(1, 1'b0, 32'h1000_0001);
      push_exp(0, 1'b0, 32'h1000_0000);
      push_exp(1, 1'b0, 32'h1000_0001);
      sim_both(4);

      // Single write then read on port 0 with per-cycle checks.
      push_exp(0, 1'b0, 32'h1000_0000);
      c0 = cyc;
      drive(0, 1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF);
      @(negedge clk);
      chk("w_stall_c0",  32'(bus.stall0),    32'd1);
      chk("w_idle_mw",   32'(bus.mem_write), 32'd0);
      @(negedge clk);
      chk("w_issue_mw",  32'(bus.mem_write), 32'd1);
      chk("w_issue_mr",  32'(bus.mem_read),  32'd0);
      chk("w_issue_adr", bus.mem_addr,       32'h10);
      chk("w_issue_wd",  bus.mem_wdata,      32'hDEAD_BEEF);
      chk("w_stall_c1",  32'(bus.stall0),    32'd1);
      chk("w_busy",      32'(bus.busy),      32'd1);
      @(negedge clk);
      chk("w_ack0",      32'(bus.ack0),      32'd1);
      chk("w_stall_c2",  32'(bus.stall0),    32'd0);
      chk("w_latency",   32'(cyc - c0),      32'd2);
      @(posedge clk); #1;
      drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
      chk("w_mem_idle",  bus.mem_addr,       32'd0);
      chk("w_committed", mem[4],             32'hDEAD_BEEF);
      txn(0, 1'b0, 32'h10, 32'd0, 1'b0, 32'hDEAD_BEEF);

      // Port isolation.
      txn(0, 1'b1, 32'h20, 32'h1234, 1'b0, 32'hDEAD_BEEF);
      txn(0, 1'b0, 32'h20, 32'd0,    1'b0, 32'h1234);
      txn(1, 1'b1, 32'h8,  32'h55,   1'b0, 32'h1000_0001);
      chk("iso_rdata0", bus.rdata0, 32'h1234);
      txn(1, 1'b0, 32'h8,  32'd0,    1'b0, 32'h55);
      chk("iso_rdata0_b", bus.rdata0, 32'h1234);

      // Misaligned write: no strobe, err with ack, memory untouched.
      w0 = wr_cnt;
      txn(1, 1'b1, 32'h6, 32'hFFFF_FFFF, 1'b1, 32'h55);
      chk("mis_no_write", 32'(wr_cnt - w0), 32'd0);
      txn(1, 1'b0, 32'h4, 32'd0, 1'b0, 32'h1000_0001);

      // Back-to-back from port 0 with changing addresses.
      r0 = rd_cnt;
      push_exp(0, 1'b0, 32'h1000_0000);
      push_exp(0, 1'b0, 32'h1000_0001);
      push_exp(0, 1'b0, 32'h55);
      c0 = cyc;
      drive(0, 1'b1, 1'b0, 32'h0, 32'd0);
      for (int k = 0; k < 3; k++) begin
         wait_ack(0, at);
         chk("b2b_gap", 32'(at - c0), (k == 0) ? 32'd2 : 32'd3);
         c0 = at;
         @(posedge clk); #1;
         if (k < 2) drive(0, 1'b1, 1'b0, (k == 0) ? 32'h4 : 32'h8, 32'd0);
      end
      drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
      chk("b2b_reads", 32'(rd_cnt - r0), 32'd3);

      // Reset in the middle of a write to 0xC.
      drive(0, 1'b1, 1'b1, 32'hC, 32'h0000_0BAD);
      @(negedge clk);
      @(negedge clk);
      chk("rm_issue_mw", 32'(bus.mem_write), 32'd1);
      #1 reset = 1'b0;
      #1;
      chk("rm_mw_drop",  32'(bus.mem_write), 32'd0);
      chk("rm_busy",     32'(bus.busy),      32'd0);
      chk("rm_rdata0",   bus.rdata0,         32'd0);
      @(posedge clk); #1;
      drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
      @(posedge clk); #1;
      reset_checks();
      chk("rm_mem_c", mem[3], 32'h1000_0003);
      reset = 1'b1;
      @(posedge clk); #1;
      push_exp(0, 1'b0, 32'h1000_0000);
      push_exp(1, 1'b0, 32'h1000_0001);
      sim_both(2);

      repeat (4) @(posedge clk);
      chk("sb_empty", 32'(sb.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
